uart_cmd_sched: RTL and testbench
=================================

# uart_cmd_sched

Round-robin scheduler that shares the single UART command master between `NREQ` on-chip requesters. Each requester posts one 24-bit command and receives the 8-bit response byte. The block grants one requester at a time and drives the master's `send_cmd`/`cmd_sent` and `resp_rdy`/`clr_resp_rdy` handshakes. It returns the response and a one-cycle done pulse to the granted requester. It sits between the capture/trigger/config logic and the UART command master.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TMO_CYCLES`, 1000000: response timeout in clk cycles; used only with `UART_SCHED_TMO_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level; held until that requester's `done` bit pulses.
- `req_cmd`  in  NREQ*24  requester i's command in bits [24*i+23:24*i]; stable while `req[i]` is high.
- `done`  out  NREQ  one-cycle pulse to the requester whose transaction has finished.
- `resp`  out  8  response byte; valid in the `done` cycle and held until the next capture.
- `tmo`  out  1  asserted in the `done` cycle when the transaction timed out.
- `busy`  out  1  high in any state other than IDLE.
- `cmd`  out  24  command to the master; registered.
- `send_cmd`  out  1  one-cycle pulse to the master.
- `cmd_sent`  in  1  master pulse: all 3 bytes transmitted.
- `resp_rdy`  in  1  master level: response byte available.
- `resp_rcv`  in  8  master response byte.
- `clr_resp_rdy`  out  1  one-cycle pulse that clears the master's `resp_rdy`.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE.
- IDLE, when any `req` bit is high:
  - The arbiter picks the winner, latches its index into `gnt` and its command into `cmd`.
  - Next state is SEND.
- SEND:
  - Pulse `send_cmd`.
  - Also pulse `clr_resp_rdy` to flush any stale response.
  - Next state is WAIT_SENT.
- WAIT_SENT: wait for `cmd_sent`, then go to WAIT_RESP. If `resp_rdy` rises here, it is held by the master and consumed in WAIT_RESP.
- WAIT_RESP, when `resp_rdy` is high:
  - Capture `resp_rcv` into `resp`.
  - Pulse `clr_resp_rdy`.
  - Next state is DONE.
- DONE:
  - Pulse `done[gnt]`.
  - Update the round-robin pointer to `gnt`.
  - Next state is IDLE.
- Round-robin rule:
  - Priority starts at (pointer+1) mod NREQ and wraps.
  - After reset the pointer is NREQ-1, so requester 0 has priority first.
  - With a single active requester, it is granted every turn.
- Requests arriving, or changing, while `busy` is high are ignored until IDLE.
- A granted requester that drops `req` mid-transaction does not abort it; `done` still pulses.
- Only one `done` bit is ever high, and only in DONE.

## Timing
- Reset values:
  - State is IDLE.
  - `done`, `tmo`, `busy`, `send_cmd` and `clr_resp_rdy` are 0.
  - `cmd` and `resp` are 0.
  - The pointer is NREQ-1.
- Reset mid-transaction returns to IDLE on the next clock edge. The master's in-flight frame is abandoned with no `done` pulse.
- `req` high in cycle N (IDLE) gives `send_cmd` in cycle N+1. `cmd` is valid from N+1 and stays constant through DONE.
- `resp_rdy` high in WAIT_RESP in cycle M gives `clr_resp_rdy` in cycle M, `resp` valid from M+1, and `done` in M+1.
- Back-to-back transactions:
  - DONE is followed by IDLE, and IDLE arbitrates in the same cycle.
  - Minimum gap is 2 cycles from `done` to the next `send_cmd`.
- `cmd_sent` and `resp_rdy` are sampled only in their own wait states.

## Configuration
- `UART_SCHED_TMO_EN` defined:
  - A counter of width `$clog2(TMO_CYCLES+1)` clears on entry to WAIT_RESP and increments each cycle there.
  - When it equals `TMO_CYCLES` without `resp_rdy`: `resp` is set to 8'h00, `clr_resp_rdy` pulses, and the state goes to DONE with `tmo`=1 in the `done` cycle.
  - If `resp_rdy` arrives in the timeout cycle, the response wins and `tmo`=0.
- Not defined:
  - No counter is built and WAIT_RESP waits indefinitely.
  - The `tmo` port remains and is tied to 0.

## Structure
- Package `uart_sched_pkg`:
  - State enum `sched_state_t`.
  - Constants `CMD_W`=24 and `RESP_W`=8.
  - Timeout response value `TMO_RESP`=8'h00.
- Sub-module `rr_arbiter` (parameter NREQ):
  - Inputs: `req`, `ptr`.
  - Output: one-hot or index `gnt`, combinational.
  - The scheduler owns the pointer register.

## Test plan
- Single request: `req`=4'b0001 with `req_cmd[23:0]`=24'hA5_12_34 -> `send_cmd` 1 cycle later with `cmd`=24'hA512_34; master model returns 8'h5A -> `done`=4'b0001, `resp`=8'h5A, `tmo`=0.
- Contention: `req`=4'b1111 held, each requester re-requesting after its `done` -> grant order 0,1,2,3,0; every `done` is one-hot.
- Stale response: `resp_rdy` forced high in IDLE before a request -> `clr_resp_rdy` pulses in SEND; the later real response 8'hC3 is returned.
- Timeout with macro and `TMO_CYCLES`=50, no response -> `done` after exactly 50 WAIT_RESP cycles, `resp`=8'h00, `tmo`=1; without macro, `busy` stays high for more than 1000 cycles.
- Reset mid-op: `rst` asserted in WAIT_SENT -> next cycle IDLE, all outputs 0; a new request is then granted to requester 0.
- Requester drops `req` after the grant -> transaction completes and `done` pulses for that requester.

Source files
------------

// File: rtl/uart_cmd_sched_pkg.sv
// Shared types and constants for the UART command scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_sched_pkg;
    localparam int CMD_W  = 24;
    localparam int RESP_W = 8;
    localparam logic [RESP_W-1:0] TMO_RESP = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        DONE
    } sched_state_t;
endpackage

// File: rtl/uart_cmd_sched_if.sv
// Handshake bundle between the scheduler (master) and the UART command master (slave).
// Latency: wires only.
// Backpressure: cmd_sent / resp_rdy from the slave pace the scheduler.
interface uart_cmd_sched_if;
    import uart_sched_pkg::*;

    logic [CMD_W-1:0]  cmd;
    logic              send_cmd;
    logic              cmd_sent;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_rcv;
    logic              clr_resp_rdy;

    modport master (
        output cmd, send_cmd, clr_resp_rdy,
        input  cmd_sent, resp_rdy, resp_rcv
    );

    modport slave (
        input  cmd, send_cmd, clr_resp_rdy,
        output cmd_sent, resp_rdy, resp_rcv
    );
endinterface

// File: rtl/uart_cmd_sched_rr_arbiter.sv
// Round-robin pick: first active requester searching from ptr+1 upward, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to use gnt.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt,
    output logic            any
);
    int idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        any = |req;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[PW'(idx)]) gnt = PW'(idx);
        end
    end
endmodule

// File: rtl/uart_cmd_sched.sv
// Shares one UART command master among NREQ requesters, round-robin; optional timeout via UART_SCHED_TMO_EN.
// Latency: req -> send_cmd 1 cycle; resp_rdy -> done 1 cycle; done -> next send_cmd 2 cycles.
// Backpressure: requests wait in IDLE while busy; cmd_sent/resp_rdy stall the FSM in their wait states.
module uart_cmd_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CMD_W-1:0] req_cmd,
    output logic [NREQ-1:0]       done,
    output logic [RESP_W-1:0]     resp,
    output logic                  tmo,
    output logic                  busy,
    uart_cmd_sched_if.master      uart
);
    localparam int PW = $clog2(NREQ);

    sched_state_t     state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt;
    logic [PW-1:0]    win;
    logic             any_req;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] win_cmd;
    logic             send_q;
    logic             tmo_q;
    logic             tmo_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (win),
        .any (any_req)
    );

    always_comb begin
        win_cmd = '0;
        for (int i = 0; i < NREQ; i++)
            if (win == PW'(i)) win_cmd = req_cmd[i*CMD_W +: CMD_W];
    end

`ifdef UART_SCHED_TMO_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // tmo_cnt counts completed WAIT_RESP cycles, so the hit lands in the TMO_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (rst)                     tmo_cnt <= '0;
        else if (state == WAIT_SENT) tmo_cnt <= '0;
        else if (state == WAIT_RESP) tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == WAIT_RESP) && (tmo_cnt == TW'(TMO_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    // The response-side clear must land in the same cycle resp_rdy is seen.
    assign uart.clr_resp_rdy = (state == SEND) ||
                               ((state == WAIT_RESP) && (uart.resp_rdy || tmo_hit));
    assign uart.cmd      = cmd_q;
    assign uart.send_cmd = send_q;
    assign busy          = (state != IDLE);
    assign tmo           = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            gnt    <= '0;
            cmd_q  <= '0;
            resp   <= '0;
            done   <= '0;
            send_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            send_q <= 1'b0;
            done   <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt    <= win;
                        cmd_q  <= win_cmd;
                        send_q <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: state <= WAIT_SENT;
                WAIT_SENT: begin
                    if (uart.cmd_sent) state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (uart.resp_rdy) begin
                        resp      <= uart.resp_rcv;
                        done[gnt] <= 1'b1;
                        state     <= DONE;
                    end else if (tmo_hit) begin
                        resp      <= TMO_RESP;
                        tmo_q     <= 1'b1;
                        done[gnt] <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= gnt;
                    tmo_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched with a behavioural UART master and a response scoreboard.
module tb_uart_cmd_sched;
    import uart_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 50;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic [NREQ-1:0]       done;
    logic [RESP_W-1:0]     resp;
    logic                  tmo;
    logic                  busy;

    uart_cmd_sched_if sif ();

    uart_cmd_sched #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_cmd (req_cmd),
        .done    (done),
        .resp    (resp),
        .tmo     (tmo),
        .busy    (busy),
        .uart    (sif)
    );

    always #5 clk = ~clk;

    // Master model: cmd_sent sent_dly+1 cycles after send_cmd, then response resp_dly+1 cycles later.
    int          sent_dly = 3;
    int          resp_dly = 4;
    bit          mute = 1'b0;
    bit          stale_set = 1'b0;
    int          m_ph;
    int          m_cnt;
    logic [23:0] m_cmd;

    function automatic logic [7:0] swapb(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    always @(posedge clk) begin
        sif.cmd_sent <= 1'b0;
        if (rst) begin
            m_ph         <= 0;
            m_cnt        <= 0;
            sif.resp_rdy <= 1'b0;
            sif.resp_rcv <= 8'h00;
        end else begin
            if (sif.clr_resp_rdy) sif.resp_rdy <= 1'b0;
            if (stale_set) begin
                sif.resp_rdy <= 1'b1;
                sif.resp_rcv <= 8'hEE;
            end
            if (sif.send_cmd) begin
                m_cmd <= sif.cmd;
                m_cnt <= sent_dly;
                m_ph  <= 1;
            end else if (m_ph == 1) begin
                if (m_cnt == 0) begin
                    sif.cmd_sent <= 1'b1;
                    m_cnt        <= resp_dly;
                    m_ph         <= 2;
                end else m_cnt <= m_cnt - 1;
            end else if (m_ph == 2 && !mute) begin
                if (m_cnt == 0) begin
                    sif.resp_rdy <= 1'b1;
                    sif.resp_rcv <= swapb(m_cmd[23:16]);
                    m_ph         <= 0;
                end else m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic [7:0]      resp;
        logic            tmo;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    int   sent_cyc = -1;
    int   done_cnt = 0;
    bit   chk_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sif.cmd_sent) sent_cyc = cyc;
        if (chk_gap && sif.send_cmd && last_done_cyc >= 0)
            check("done_to_send_gap", cyc - last_done_cyc, 2);
        if (done !== '0) begin
            check("done_onehot", $countones(done), 1);
            if (sb.size() == 0) check("unexpected_done", done, 0);
            else begin
                e = sb.pop_front();
                check("done", done, e.done);
                check("resp", resp, e.resp);
                check("tmo", tmo, e.tmo);
            end
            last_done_cyc = cyc;
            done_cnt++;
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        int start = done_cnt;
        for (int i = 0; i < limit && done_cnt == start; i++) tick();
        if (done_cnt == start) check({tag, "_wait_expired"}, done_cnt - start, 1);
    endtask

    task automatic set_req(input int i, input logic [23:0] c);
        req[i] = 1'b1;
        req_cmd[i*CMD_W +: CMD_W] = c;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_tmo"}, tmo, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_send_cmd"}, sif.send_cmd, 0);
        check({tag, "_clr_resp_rdy"}, sif.clr_resp_rdy, 0);
        check({tag, "_cmd"}, sif.cmd, 0);
        check({tag, "_resp"}, resp, 0);
    endtask

    logic [23:0] ccmd [NREQ];
    logic [7:0]  cresp [NREQ];
    int          dc;

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_cmd = '0;
        ccmd[0] = 24'h12AA00; cresp[0] = 8'h21;
        ccmd[1] = 24'h34BB01; cresp[1] = 8'h43;
        ccmd[2] = 24'h56CC02; cresp[2] = 8'h65;
        ccmd[3] = 24'h78DD03; cresp[3] = 8'h87;

        repeat (2) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single request
        set_req(0, 24'hA51234);
        sb.push_back(exp_t'{done: 4'b0001, resp: 8'h5A, tmo: 1'b0});
        tick();
        check("single_send_cmd", sif.send_cmd, 1);
        check("single_cmd", sif.cmd, 24'hA51234);
        check("single_busy", busy, 1);
        tick();
        check("single_send_pulse", sif.send_cmd, 0);
        check("single_cmd_held", sif.cmd, 24'hA51234);
        wait_done(100, "single");
        req[0] = 1'b0;
        tick();
        check("single_back_idle", busy, 0);

        // Contention from reset: order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_done_cyc = -1;
        chk_gap = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, ccmd[i]);
        for (int k = 0; k < 5; k++)
            sb.push_back(exp_t'{done: 4'(1 << (k % NREQ)), resp: cresp[k % NREQ], tmo: 1'b0});
        for (int k = 0; k < 5; k++) wait_done(100, "rr");
        req = '0;
        chk_gap = 1'b0;
        tick();
        check("rr_back_idle", busy, 0);

        // Stale response in IDLE is flushed in SEND
        stale_set = 1'b1;
        tick();
        stale_set = 1'b0;
        tick();
        check("stale_idle_no_clr", sif.clr_resp_rdy, 0);
        set_req(2, 24'h3C0102);
        sb.push_back(exp_t'{done: 4'b0100, resp: 8'hC3, tmo: 1'b0});
        tick();
        check("stale_send_cmd", sif.send_cmd, 1);
        check("stale_clr_in_send", sif.clr_resp_rdy, 1);
        wait_done(100, "stale");
        req[2] = 1'b0;
        tick();

        // Requester drops req after grant
        set_req(1, 24'h9F0000);
        sb.push_back(exp_t'{done: 4'b0010, resp: 8'hF9, tmo: 1'b0});
        tick();
        check("drop_send_cmd", sif.send_cmd, 1);
        req[1] = 1'b0;
        wait_done(100, "drop");
        tick();

        // No response from the master
        mute = 1'b1;
`ifdef UART_SCHED_TMO_EN
        set_req(3, 24'hEE0000);
        sb.push_back(exp_t'{done: 4'b1000, resp: 8'h00, tmo: 1'b0 | 1'b1});
        sent_cyc = -1;
        wait_done(300, "timeout");
        req[3] = 1'b0;
        check("timeout_latency", last_done_cyc - sent_cyc, TMO + 1);
        tick();
        check("timeout_tmo_cleared", tmo, 0);
`else
        set_req(3, 24'hEE0000);
        dc = done_cnt;
        repeat (1100) tick();
        check("no_tmo_busy", busy, 1);
        check("no_tmo_no_done", done_cnt - dc, 0);
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        mute = 1'b0;

        // Reset during WAIT_SENT
        sent_dly = 6;
        set_req(1, 24'h111111);
        tick();
        tick();
        check("midop_busy", busy, 1);
        rst = 1'b1;
        req = '0;
        tick();
        check_idle_outputs("midop_reset");
        rst = 1'b0;
        sent_dly = 3;
        set_req(0, 24'hC50000);
        set_req(2, 24'hD70000);
        sb.push_back(exp_t'{done: 4'b0001, resp: 8'h5C, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0100, resp: 8'h7D, tmo: 1'b0});
        wait_done(100, "after_reset_0");
        req[0] = 1'b0;
        wait_done(100, "after_reset_2");
        req[2] = 1'b0;
        tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
